// File: rtl/cursor_ctrl.sv
// Push-button cursor controller: synchronizes four buttons, debounces the
// winning direction and moves a clamped cursor square with auto-repeat.
module cursor_ctrl #(
    parameter int SIZE            = 8,
    parameter int STEP            = 4,
    parameter int W_RES           = 640,
    parameter int H_RES           = 480,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 2000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        up_but,
    input  logic        down_but,
    input  logic        left_but,
    input  logic        right_but,
    output logic [10:0] cursor_x,
    output logic [10:0] cursor_y,
    output logic        moved,
    output logic [1:0]  dir
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, REPEAT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [11:0] X_MAX  = 12'(W_RES - SIZE);
    localparam logic [11:0] Y_MAX  = 12'(H_RES - SIZE);
    localparam logic [10:0] X_HOME = 11'((W_RES - SIZE) / 2);
    localparam logic [10:0] Y_HOME = 11'((H_RES - SIZE) / 2);

    // Bit order {right, left, down, up}; buttons are active-low, so idle is all ones.
    logic [3:0] btn_meta, btn_sync;
    logic [3:0] pressed;
    logic       any_pressed;
    dir_t       sel;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, limit;
    dir_t        ldir, ldir_n;
    logic        step;

    logic [11:0] x_ext, y_ext, x_inc, y_inc;
    logic [10:0] x_n, y_n;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the
    // two-flop synchronizer into a single stage.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            btn_meta <= 4'b1111;
            btn_sync <= 4'b1111;
        end else begin
            btn_meta <= {right_but, left_but, down_but, up_but};
            btn_sync <= btn_meta;
        end
    end

    assign pressed     = ~btn_sync;
    assign any_pressed = |pressed;

    always_comb begin
        sel = DIR_UP;
        if (pressed[0])      sel = DIR_UP;
        else if (pressed[1]) sel = DIR_DOWN;
        else if (pressed[2]) sel = DIR_LEFT;
        else if (pressed[3]) sel = DIR_RIGHT;
    end

    always_comb begin
        case (state)
            DEBOUNCE: limit = 32'(DEBOUNCE_CYCLES - 1);
            HOLD:     limit = 32'(REPEAT_DELAY - 1);
            default:  limit = 32'(REPEAT_RATE - 1);
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ldir_n  = ldir;
        step    = 1'b0;
        case (state)
            IDLE: begin
                if (any_pressed) begin
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                    ldir_n  = sel;
                end
            end
            default: begin
                if (!any_pressed) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (sel != ldir) begin
                    // A new winning direction must be debounced from scratch.
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                    ldir_n  = sel;
                end else if (cnt == limit) begin
                    step    = 1'b1;
                    cnt_n   = '0;
                    state_n = (state == DEBOUNCE) ? HOLD : REPEAT;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            ldir  <= DIR_UP;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ldir  <= ldir_n;
        end
    end

    // Widened to 12 bits so the bottom/right sums can exceed the limit without wrapping.
    assign x_ext = {1'b0, cursor_x};
    assign y_ext = {1'b0, cursor_y};
    assign x_inc = x_ext + STEP12;
    assign y_inc = y_ext + STEP12;

    always_comb begin
        x_n = cursor_x;
        y_n = cursor_y;
        case (ldir)
            DIR_UP:    y_n = (y_ext < STEP12) ? 11'd0 : 11'(y_ext - STEP12);
            DIR_DOWN:  y_n = (y_inc > Y_MAX)  ? 11'(Y_MAX) : 11'(y_inc);
            DIR_LEFT:  x_n = (x_ext < STEP12) ? 11'd0 : 11'(x_ext - STEP12);
            DIR_RIGHT: x_n = (x_inc > X_MAX)  ? 11'(X_MAX) : 11'(x_inc);
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cursor_x <= X_HOME;
            cursor_y <= Y_HOME;
            moved    <= 1'b0;
            dir      <= 2'd0;
        end else begin
            moved <= step;
            if (step) begin
                cursor_x <= x_n;
                cursor_y <= y_n;
                dir      <= ldir;
            end
        end
    end

endmodule

// File: tb/tb_cursor_ctrl.sv
// Bench for cursor_ctrl: a per-edge behavioural model checked every cycle,
// plus directed scenarios with hand-computed positions and timings.
module tb_cursor_ctrl;

    localparam int SIZE  = 8;
    localparam int STEP  = 4;
    localparam int W_RES = 640;
    localparam int H_RES = 480;
    localparam int DEB   = 4;
    localparam int RD    = 10;
    localparam int RR    = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset     = 1'b0;
    logic        up_but    = 1'b1;
    logic        down_but  = 1'b1;
    logic        left_but  = 1'b1;
    logic        right_but = 1'b1;
    logic [10:0] cursor_x, cursor_y;
    logic        moved;
    logic [1:0]  dir;

    always #10 CLOCK_50 = ~CLOCK_50;

    cursor_ctrl #(
        .SIZE(SIZE), .STEP(STEP), .W_RES(W_RES), .H_RES(H_RES),
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .up_but   (up_but),
        .down_but (down_but),
        .left_but (left_but),
        .right_but(right_but),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .moved    (moved),
        .dir      (dir)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a press streak counts consecutive edges on which the same
    // direction wins; steps fall at fixed streak lengths.
    int mx, my, mdir, streak, last_sel;
    bit mmoved, model_valid;
    bit [3:0] p1, p2;

    function automatic int pick(input bit [3:0] p);
        if (p[0]) return 0;
        if (p[1]) return 1;
        if (p[2]) return 2;
        if (p[3]) return 3;
        return -1;
    endfunction

    function automatic bit is_step(input int n);
        int first, second;
        first  = 1 + DEB;
        second = first + RD;
        return (n == first) || (n == second) || (n > second && (n - second) % RR == 0);
    endfunction

    always @(posedge CLOCK_50) begin
        int sel;
        if (!reset) begin
            mx = (W_RES - SIZE) / 2;
            my = (H_RES - SIZE) / 2;
            mdir = 0;
            mmoved = 1'b0;
            p1 = '0;
            p2 = '0;
            streak = 0;
            last_sel = -1;
        end else begin
            sel = pick(p2);
            if (sel < 0) streak = 0;
            else if (sel == last_sel && streak > 0) streak++;
            else streak = 1;
            last_sel = sel;
            mmoved = (sel >= 0) && is_step(streak);
            if (mmoved) begin
                mdir = sel;
                case (sel)
                    0: my = (my < STEP) ? 0 : my - STEP;
                    1: my = (my + STEP > H_RES - SIZE) ? H_RES - SIZE : my + STEP;
                    2: mx = (mx < STEP) ? 0 : mx - STEP;
                    default: mx = (mx + STEP > W_RES - SIZE) ? W_RES - SIZE : mx + STEP;
                endcase
            end
            p2 = p1;
            p1 = ~{right_but, left_but, down_but, up_but};
        end
        model_valid = 1'b1;
    end

    always @(negedge CLOCK_50) begin
        if (model_valid) begin
            check("model_x", 32'(cursor_x), 32'(mx));
            check("model_y", 32'(cursor_y), 32'(my));
            check("model_moved", 32'(moved), 32'(mmoved));
            check("model_dir", 32'(dir), 32'(mdir));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic expect_pos(input string tag, input int x, input int y, input int mv, input int d);
        check({tag, "_x"}, 32'(cursor_x), 32'(x));
        check({tag, "_y"}, 32'(cursor_y), 32'(y));
        check({tag, "_moved"}, 32'(moved), 32'(mv));
        check({tag, "_dir"}, 32'(dir), 32'(d));
    endtask

    int pulses;

    initial begin
        // Reset held for three edges.
        tick(3);
        reset = 1'b1;
        expect_pos("reset", 316, 236, 0, 0);
        tick(2);
        expect_pos("idle_after_reset", 316, 236, 0, 0);

        // Right held 40 cycles: steps at edges 6, 16, then every 3 edges.
        right_but = 1'b0;
        tick(6);
        expect_pos("right_e5", 316, 236, 0, 0);
        tick(1);
        expect_pos("right_e6", 320, 236, 1, 3);
        tick(1);
        check("right_e7_moved", 32'(moved), 32'd0);
        tick(9);
        expect_pos("right_e16", 324, 236, 1, 3);
        tick(3);
        expect_pos("right_e19", 328, 236, 1, 3);
        tick(20);
        right_but = 1'b1;
        tick(6);
        expect_pos("right_done", 356, 236, 0, 3);

        // Three-cycle glitch on up never steps.
        pulses = 0;
        up_but = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (moved) pulses++;
        end
        up_but = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (moved) pulses++;
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        expect_pos("glitch_pos", 356, 236, 0, 3);

        // Up held 200 cycles: 63 steps, the last five land on y=0.
        pulses = 0;
        up_but = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (moved && cursor_y == 11'd0) pulses++;
        end
        up_but = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (moved && cursor_y == 11'd0) pulses++;
        end
        check("up_clamp_pulses", 32'(pulses), 32'd5);
        expect_pos("up_top", 356, 0, 0, 0);

        // Down to the bottom clamp, then right to the right clamp.
        down_but = 1'b0;
        tick(400);
        down_but = 1'b1;
        tick(6);
        expect_pos("down_bottom", 356, 472, 0, 1);
        right_but = 1'b0;
        tick(260);
        right_but = 1'b1;
        tick(6);
        expect_pos("right_edge", 632, 472, 0, 3);

        // Up and left together: up wins; dropping up restarts the debounce.
        up_but = 1'b0;
        left_but = 1'b0;
        tick(7);
        expect_pos("upleft_e6", 632, 468, 1, 0);
        tick(1);
        up_but = 1'b1;
        tick(6);
        expect_pos("left_e13", 632, 468, 0, 0);
        tick(1);
        expect_pos("left_e14", 628, 468, 1, 2);
        tick(14);
        reset = 1'b0;
        tick(1);
        expect_pos("reset_mid_repeat", 316, 236, 0, 0);
        tick(1);
        reset = 1'b1;
        tick(6);
        expect_pos("held_through_reset_e36", 316, 236, 0, 0);
        tick(1);
        expect_pos("held_through_reset_e37", 312, 236, 1, 2);
        left_but = 1'b1;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
